// File: rtl/mc_datapath_pkg.sv
// Shared encodings for the multicycle datapath:
// opcodes, ALU operations and B-operand selects.
package mc_datapath_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_SHL  = 3'b110,
    ALU_PASS = 3'b111
  } aluop_e;

  typedef enum logic [2:0] {
    SELB_REG  = 3'b000,
    SELB_ONE  = 3'b001,
    SELB_SEXT = 3'b010,
    SELB_ZEXT = 3'b011
  } selb_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU with its own A/B operand muxes.
// Arithmetic wraps mod 2^DATA_W; carry is dropped.
module mc_alu
  import mc_datapath_pkg::*;
(
  input  logic [2:0]        op,
  input  logic              sel_a,
  input  logic [2:0]        sel_b,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        imm,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign opa = sel_a ? a : pc;

  always_comb begin
    opb = '0;
    case (sel_b)
      SELB_REG:  opb = b;
      SELB_ONE:  opb = DATA_W'(1);
      SELB_SEXT: opb = {{(DATA_W-4){imm[3]}}, imm};
      SELB_ZEXT: opb = {{(DATA_W-4){1'b0}}, imm};
      default:   opb = '0;
    endcase
  end

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = opa + opb;
      ALU_SUB:  y = opa - opb;
      ALU_AND:  y = opa & opb;
      ALU_OR:   y = opa | opb;
      ALU_XOR:  y = opa ^ opb;
      ALU_NOT:  y = ~opa;
      ALU_SHL:  y = {opa[DATA_W-2:0], 1'b0};
      ALU_PASS: y = opb;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: PC/IR/MDR/A/B/ALUout, 4x8 register
// file and memory muxes, steered by FSM strobes each cycle.
module mc_datapath #(
  parameter int                DATA_W   = mc_datapath_pkg::DATA_W,
  parameter int                NREG     = 4,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RFWrite,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              PCWrite,
  input  logic              IRload,
  input  logic              MDRload,
  input  logic              ABLD,
  input  logic              ALUoutLD,
  input  logic [2:0]        ALUop,
  input  logic              ALUA,
  input  logic [2:0]        ALU_B,
  input  logic              Addrsel,
  input  logic              RASel,
  input  logic              RegIn,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              zero,
  output logic [DATA_W-1:0] pc
);

  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] rf [NREG];
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic [1:0]        wa;
  logic [DATA_W-1:0] wd;

  assign ra = RASel ? IR[1:0] : IR[5:4];
  assign rb = IR[3:2];
  assign wa = IR[5:4];
  assign wd = RegIn ? mdr : alu_out;

  assign mem_addr  = Addrsel ? b : pc;
  assign mem_wdata = a;
  assign mem_read  = MemRead;
  assign mem_write = MemWrite;

  mc_alu u_alu (
    .op    (ALUop),
    .sel_a (ALUA),
    .sel_b (ALU_B),
    .pc    (pc),
    .a     (a),
    .b     (b),
    .imm   (IR[3:0]),
    .y     (alu_y)
  );

  // Nonblocking reads give A/B the pre-write register values.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= PC_RESET;
      IR      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      zero    <= 1'b1;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (PCWrite)  pc  <= pc + DATA_W'(1);
      if (IRload)   IR  <= mem_rdata;
      if (MDRload)  mdr <= mem_rdata;
      if (ABLD) begin
        a <= rf[ra];
        b <= rf[rb];
      end
      if (ALUoutLD) begin
        alu_out <= alu_y;
        zero    <= (alu_y == '0);
      end
      if (RFWrite) rf[wa] <= wd;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath with a behavioural
// combinational-read memory and hand-computed expectations.
module tb_mc_datapath;

  logic       clock = 1'b0;
  logic       reset;
  logic       RFWrite, MemWrite, MemRead, PCWrite;
  logic       IRload, MDRload, ABLD, ALUoutLD;
  logic [2:0] ALUop;
  logic       ALUA;
  logic [2:0] ALU_B;
  logic       Addrsel, RASel, RegIn;
  logic [7:0] IR, mem_addr, mem_wdata, mem_rdata, pc;
  logic       mem_read, mem_write, zero;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clock = ~clock;

  mc_datapath dut (
    .clock     (clock),
    .reset     (reset),
    .RFWrite   (RFWrite),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PCWrite   (PCWrite),
    .IRload    (IRload),
    .MDRload   (MDRload),
    .ABLD      (ABLD),
    .ALUoutLD  (ALUoutLD),
    .ALUop     (ALUop),
    .ALUA      (ALUA),
    .ALU_B     (ALU_B),
    .Addrsel   (Addrsel),
    .RASel     (RASel),
    .RegIn     (RegIn),
    .IR        (IR),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .zero      (zero),
    .pc        (pc)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    RFWrite = 0; MemWrite = 0; MemRead = 0; PCWrite = 0;
    IRload = 0; MDRload = 0; ABLD = 0; ALUoutLD = 0;
    ALUop = 3'b000; ALUA = 0; ALU_B = 3'b000;
    Addrsel = 0; RASel = 0; RegIn = 0;
  endtask

  task automatic tick();
    logic       wr;
    logic [7:0] wa;
    logic [7:0] wd;
    wr = mem_write;
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clock);
    if (wr) mem[wa] = wd;
    #1;
    idle();
  endtask

  task automatic load_ir(input logic [7:0] v);
    mem[pc] = v;
    MemRead = 1; IRload = 1;
    tick();
  endtask

  task automatic set_reg(input logic [1:0] r,
                         input logic [7:0] v);
    load_ir({2'b00, r, 4'h0});
    mem[pc] = v;
    MemRead = 1; MDRload = 1;
    tick();
    RegIn = 1; RFWrite = 1;
    tick();
  endtask

  task automatic read_a(input logic [1:0] r,
                        input logic [7:0] exp,
                        input string tag);
    load_ir({2'b00, r, 4'h0});
    ABLD = 1;
    tick();
    chk(tag, mem_wdata, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", IR, 8'h00);
    chk("rst_zero", {7'd0, zero}, 8'h01);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_a", mem_wdata, 8'h00);
    Addrsel = 1;
    #1 chk("rst_b", mem_addr, 8'h00);
    idle();

    mem[0] = 8'h24;
    MemRead = 1; IRload = 1; PCWrite = 1;
    #1 chk("fetch_rd", {7'd0, mem_read}, 8'h01);
    tick();
    chk("fetch_ir", IR, 8'h24);
    chk("fetch_pc", pc, 8'h01);

    set_reg(2'd1, 8'h05);
    set_reg(2'd2, 8'h07);
    load_ir(8'h18);
    ABLD = 1;
    tick();
    chk("add_a", mem_wdata, 8'h05);
    Addrsel = 1;
    #1 chk("add_b", mem_addr, 8'h07);
    idle();
    ALUA = 1; ALUoutLD = 1;
    tick();
    chk("add_zero", {7'd0, zero}, 8'h00);
    RFWrite = 1;
    tick();
    ABLD = 1;
    tick();
    chk("add_r1", mem_wdata, 8'h0C);

    set_reg(2'd1, 8'h09);
    set_reg(2'd2, 8'h09);
    load_ir(8'h18);
    ABLD = 1;
    tick();
    ALUA = 1; ALUop = 3'b001; ALUoutLD = 1;
    tick();
    chk("sub_zero", {7'd0, zero}, 8'h01);
    RFWrite = 1;
    tick();
    ABLD = 1;
    tick();
    chk("sub_r1", mem_wdata, 8'h00);

    set_reg(2'd2, 8'h40);
    mem[8'h40] = 8'hA5;
    load_ir(8'h38);
    ABLD = 1;
    tick();
    Addrsel = 1;
    #1 chk("ld_addr", mem_addr, 8'h40);
    MemRead = 1; MDRload = 1;
    tick();
    RegIn = 1; RFWrite = 1;
    tick();
    read_a(2'd3, 8'hA5, "ld_r3");

    set_reg(2'd0, 8'h3C);
    load_ir(8'h08);
    ABLD = 1;
    tick();
    MemWrite = 1; Addrsel = 1;
    #1;
    chk("st_we", {7'd0, mem_write}, 8'h01);
    chk("st_addr", mem_addr, 8'h40);
    chk("st_data", mem_wdata, 8'h3C);
    tick();
    chk("st_we_off", {7'd0, mem_write}, 8'h00);
    chk("st_mem", mem[8'h40], 8'h3C);

    load_ir(8'h0C);
    ALUop = 3'b111; ALU_B = 3'b010; ALUoutLD = 1;
    tick();
    chk("sext_zero", {7'd0, zero}, 8'h00);
    RFWrite = 1;
    tick();
    ABLD = 1;
    tick();
    chk("sext_r0", mem_wdata, 8'hFC);

    mem[pc] = 8'h2B;
    MemRead = 1; IRload = 1; MDRload = 1;
    tick();
    chk("irmdr_ir", IR, 8'h2B);
    RegIn = 1; RFWrite = 1;
    tick();
    ABLD = 1;
    tick();
    Addrsel = 1;
    #1 chk("irmdr_r2", mem_addr, 8'h2B);
    idle();

    set_reg(2'd1, 8'h11);
    load_ir(8'h14);
    ALUop = 3'b111; ALU_B = 3'b011; ALUoutLD = 1;
    tick();
    ABLD = 1; RFWrite = 1;
    tick();
    chk("nobyp_old", mem_wdata, 8'h11);
    ABLD = 1;
    tick();
    chk("nobyp_new", mem_wdata, 8'h04);

    load_ir(8'h01);
    ABLD = 1; RASel = 1;
    tick();
    chk("rasel", mem_wdata, 8'h04);

    repeat (254) begin
      PCWrite = 1;
      tick();
    end
    chk("pc_ff", pc, 8'hFF);
    mem[8'hFF] = 8'h77;
    MemRead = 1; IRload = 1; PCWrite = 1;
    tick();
    chk("wrap_ir", IR, 8'h77);
    chk("wrap_pc", pc, 8'h00);

    reset = 1; RFWrite = 1; ALUoutLD = 1;
    tick();
    reset = 0;
    chk("rst2_pc", pc, 8'h00);
    chk("rst2_zero", {7'd0, zero}, 8'h01);
    read_a(2'd3, 8'h00, "rst2_r3");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
